// File: rtl/oled_spi_sink.sv
// SSD1306-style SPI receive sink: byte assembly, command decoder, and a GDDRAM
// shadow with a windowed, horizontally auto-incrementing write pointer.
//   state   | meaning
//   S_IDLE  | waiting for an opcode
//   S_ARG_A | expecting window start (column or page)
//   S_ARG_B | expecting window end
//   S_SKIP1 | one-byte argument (contrast, or discarded)
module oled_spi_sink #(
  parameter int COLS  = 128,
  parameter int PAGES = 4,
  parameter int TOUT  = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sdin,
  input  logic                                sclk,
  input  logic                                dc,
  input  logic [$clog2(COLS*PAGES)-1:0]       rd_addr,
  output logic [7:0]                          rd_data,
  output logic                                byte_valid,
  output logic [7:0]                          byte_out,
  output logic                                byte_dc,
  output logic                                disp_on,
  output logic [7:0]                          contrast,
  output logic                                cmd_err
);
  localparam int AW    = $clog2(COLS*PAGES);
  localparam int CW    = $clog2(COLS);
  localparam int PW    = $clog2(PAGES);
  localparam int TW    = $clog2(TOUT+1);
  localparam int DEPTH = COLS*PAGES;

  typedef enum logic [1:0] {S_IDLE, S_ARG_A, S_ARG_B, S_SKIP1} state_t;

  logic          r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic          r_sdin_s1, r_sdin_s2, r_dc_s1, r_dc_s2;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic [TW-1:0] r_tout_cnt;
  logic          r_byte_valid, r_byte_dc;
  logic [7:0]    r_byte_out;
  state_t        r_state, w_state_nxt;
  logic          r_tgt_page, w_tgt_page_nxt;
  logic          r_skip_ctr, w_skip_ctr_nxt;
  logic          w_disp_set, w_disp_clr, w_err_set, w_start_ld, w_end_ld, w_contrast_ld;
  logic          r_disp_on, r_cmd_err;
  logic [7:0]    r_contrast;
  logic [CW-1:0] r_arg_start, r_col_start, r_col_end, r_col_ptr;
  logic [PW-1:0] r_page_start, r_page_end, r_page_ptr;
  logic [CW-1:0] w_col_s, w_col_e;
  logic [PW-1:0] w_page_s, w_page_e;
  logic [AW-1:0] w_wr_addr;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_rd_data;
  logic          w_rise, w_cmd, w_data;

  assign w_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_cmd  = r_byte_valid & ~r_byte_dc;
  assign w_data = r_byte_valid & r_byte_dc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      {r_sclk_s1, r_sclk_s2, r_sclk_d} <= 3'b111;
      {r_sdin_s1, r_sdin_s2, r_dc_s1, r_dc_s2} <= 4'b0000;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_sdin_s1 <= sdin;
      r_sdin_s2 <= r_sdin_s1;
      r_dc_s1   <= dc;
      r_dc_s2   <= r_dc_s1;
    end
  end

  // Idle timer reloads on every SCLK edge; reaching terminal count drops a partial byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tout_cnt   <= '0;
      r_byte_valid <= 1'b0;
      r_byte_out   <= '0;
      r_byte_dc    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_rise) begin
        r_tout_cnt <= TW'(TOUT);
        if (r_bit_cnt == 3'd7) begin
          r_byte_out   <= {r_shift, r_sdin_s2};
          r_byte_dc    <= r_dc_s2;
          r_byte_valid <= 1'b1;
          r_bit_cnt    <= '0;
        end else begin
          r_shift   <= {r_shift[5:0], r_sdin_s2};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end else if (r_tout_cnt != '0) begin
        r_tout_cnt <= r_tout_cnt - 1'b1;
        if (r_tout_cnt == TW'(1)) r_bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tgt_page <= 1'b0;
      r_skip_ctr <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt_page <= w_tgt_page_nxt;
      r_skip_ctr <= w_skip_ctr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_page_nxt = r_tgt_page;
    w_skip_ctr_nxt = r_skip_ctr;
    w_disp_set     = 1'b0;
    w_disp_clr     = 1'b0;
    w_err_set      = 1'b0;
    w_start_ld     = 1'b0;
    w_end_ld       = 1'b0;
    w_contrast_ld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd) begin
          case (r_byte_out)
            8'hAE: w_disp_clr = 1'b1;
            8'hAF: w_disp_set = 1'b1;
            8'h21: begin w_tgt_page_nxt = 1'b0; w_state_nxt = S_ARG_A; end
            8'h22: begin w_tgt_page_nxt = 1'b1; w_state_nxt = S_ARG_A; end
            8'h81: begin w_skip_ctr_nxt = 1'b1; w_state_nxt = S_SKIP1; end
            8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
              w_skip_ctr_nxt = 1'b0;
              w_state_nxt    = S_SKIP1;
            end
            default: ;
          endcase
        end
      end
      S_ARG_A, S_ARG_B, S_SKIP1: begin
        // A data byte mid-command aborts the command but is still stored.
        if (w_data) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cmd) begin
          if (r_state == S_ARG_A) begin
            w_start_ld  = 1'b1;
            w_state_nxt = S_ARG_B;
          end else begin
            w_end_ld      = (r_state == S_ARG_B);
            w_contrast_ld = (r_state == S_SKIP1) && r_skip_ctr;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_col_s  = r_arg_start;
  assign w_col_e  = (r_byte_out[CW-1:0] < w_col_s) ? w_col_s : r_byte_out[CW-1:0];
  assign w_page_s = r_arg_start[PW-1:0];
  assign w_page_e = (r_byte_out[PW-1:0] < w_page_s) ? w_page_s : r_byte_out[PW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp_on    <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_contrast   <= 8'h7F;
      r_arg_start  <= '0;
      r_col_start  <= '0;
      r_col_end    <= CW'(COLS-1);
      r_col_ptr    <= '0;
      r_page_start <= '0;
      r_page_end   <= PW'(PAGES-1);
      r_page_ptr   <= '0;
    end else begin
      if (w_disp_set) r_disp_on <= 1'b1;
      if (w_disp_clr) r_disp_on <= 1'b0;
      if (w_err_set) r_cmd_err <= 1'b1;
      if (w_contrast_ld) r_contrast <= r_byte_out;
      if (w_start_ld) r_arg_start <= r_byte_out[CW-1:0];
      if (w_end_ld) begin
        if (r_tgt_page) begin
          r_page_start <= w_page_s;
          r_page_end   <= w_page_e;
          r_page_ptr   <= w_page_s;
        end else begin
          r_col_start <= w_col_s;
          r_col_end   <= w_col_e;
          r_col_ptr   <= w_col_s;
        end
      end
      if (w_data) begin
        if (r_col_ptr == r_col_end) begin
          r_col_ptr  <= r_col_start;
          r_page_ptr <= (r_page_ptr == r_page_end) ? r_page_start : r_page_ptr + 1'b1;
        end else begin
          r_col_ptr <= r_col_ptr + 1'b1;
        end
      end
    end
  end

  assign w_wr_addr = AW'(r_page_ptr) * AW'(COLS) + AW'(r_col_ptr);

  always_ff @(posedge clk) begin
    if (w_data) r_mem[w_wr_addr] <= r_byte_out;
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data    = r_rd_data;
  assign byte_valid = r_byte_valid;
  assign byte_out   = r_byte_out;
  assign byte_dc    = r_byte_dc;
  assign disp_on    = r_disp_on;
  assign contrast   = r_contrast;
  assign cmd_err    = r_cmd_err;

endmodule
